dwa_rotator_18: RTL and testbench

- Dynamic element matching (data-weighted averaging) stage. It sits directly downstream of the 5-to-18 beta thermometer decoder.
- It consumes the 18-bit thermometer word and rotates the active-element window by a running pointer, so each of the 18 unit elements of the beta DAC segment is used equally over time.
- The registered, rotated selection vector drives the unit-element switch drivers.

---
 rtl/dac_pkg.sv | 19 +
 rtl/therm2cnt_18.sv | 29 ++
 rtl/dwa_rotator_18.sv | 80 ++++++++
 tb/tb_dwa_rotator_18.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants and pointer arithmetic for the beta-segment DWA stage.
package dac_pkg;

  localparam int unsigned N_ELEM = 18;
  localparam int unsigned PTR_W  = 5;

  // Wrapped pointer advance: 6-bit sum, then at most one subtract of N_ELEM.
  // The sum peaks at 17 + 18 = 35, so a single correction is always enough.
  function automatic logic [PTR_W-1:0] mod_add_18(input logic [PTR_W-1:0] ptr,
                                                  input logic [PTR_W-1:0] cnt);
    logic [PTR_W:0] sum;
    sum = {1'b0, ptr} + {1'b0, cnt};
    if (sum >= (PTR_W + 1)'(N_ELEM)) begin
      sum = sum - (PTR_W + 1)'(N_ELEM);
    end
    return sum[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/therm2cnt_18.sv
// Popcount of the 18-bit thermometer word plus a well-formed-code flag.
module therm2cnt_18
  import dac_pkg::*;
(
  input  logic [N_ELEM-1:0] i_therm,
  output logic [PTR_W-1:0]  o_cnt,
  output logic              o_valid
);

  logic [PTR_W-1:0] w_cnt;
  logic [N_ELEM:0]  w_ideal;

  // Count ones; the result drives both the rotation width and the pointer step.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < int'(N_ELEM); i++) begin
      w_cnt = w_cnt + PTR_W'(i_therm[i]);
    end
  end

  // A legal code is exactly cnt ones packed at the LSB end.
  always_comb begin
    w_ideal = ((N_ELEM + 1)'(1) << w_cnt) - (N_ELEM + 1)'(1);
  end

  assign o_cnt   = w_cnt;
  assign o_valid = ({1'b0, i_therm} == w_ideal);

endmodule

// File: rtl/dwa_rotator_18.sv
// Data-weighted-averaging rotator: turns the thermometer word into a rotated
// unit-element window so all 18 beta elements wear evenly.
module dwa_rotator_18
  import dac_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic [N_ELEM-1:0] i_therm_in,
  input  logic              i_dwa_en,
  output logic [N_ELEM-1:0] o_elem_sel,
  output logic              o_out_valid,
  output logic [PTR_W-1:0]  o_ptr,
  output logic              o_therm_err
);

  localparam int unsigned DblW = 2 * N_ELEM;

  logic [PTR_W-1:0]  w_cnt;
  logic              w_therm_ok;
  logic [DblW-1:0]   w_mask;
  logic [DblW-1:0]   w_shifted;
  logic [N_ELEM-1:0] w_rot_sel;

  logic [N_ELEM-1:0] r_elem_sel;
  logic              r_out_valid;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_therm_err;

  therm2cnt_18 u_therm2cnt (
    .i_therm (i_therm_in),
    .o_cnt   (w_cnt),
    .o_valid (w_therm_ok)
  );

  // Window of cnt ones rebuilt from the count, so a bubbled code still lights
  // the right number of elements; shift into a double-width field and fold the
  // overflow back onto the low half to wrap bit 17 into bit 0.
  always_comb begin
    w_mask    = (DblW'(1) << w_cnt) - DblW'(1);
    w_shifted = w_mask << r_ptr;
    w_rot_sel = w_shifted[DblW-1:N_ELEM] | w_shifted[N_ELEM-1:0];
  end

  // Output and pointer registers; reset wins over an incoming sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_elem_sel  <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
      r_therm_err <= 1'b0;
    end else if (i_in_valid) begin
      r_out_valid <= 1'b1;
      r_therm_err <= ~w_therm_ok;
      if (i_dwa_en) begin
        r_elem_sel <= w_rot_sel;
        r_ptr      <= mod_add_18(r_ptr, w_cnt);
      end else begin
        r_elem_sel <= i_therm_in;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_therm_err <= 1'b0;
    end
  end

  // Pointer must stay inside the element range.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (r_ptr < PTR_W'(N_ELEM))
        else $error("dwa_rotator_18: ptr out of range %0d", r_ptr);
    end
  end

  assign o_elem_sel  = r_elem_sel;
  assign o_out_valid = r_out_valid;
  assign o_ptr       = r_ptr;
  assign o_therm_err = r_therm_err;

endmodule

// File: tb/tb_dwa_rotator_18.sv
// Directed and soak bench for dwa_rotator_18.
module tb_dwa_rotator_18;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [17:0] therm_in;
  logic        dwa_en;
  logic [17:0] elem_sel;
  logic        out_valid;
  logic [4:0]  ptr;
  logic        therm_err;

  int n_pass  = 0;
  int n_total = 0;

  dwa_rotator_18 dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .i_therm_in  (therm_in),
    .i_dwa_en    (dwa_en),
    .o_elem_sel  (elem_sel),
    .o_out_valid (out_valid),
    .o_ptr       (ptr),
    .o_therm_err (therm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge, then wait until just after
  // the next rising edge so outputs can be sampled.
  task automatic step(input logic r, input logic v, input logic [17:0] t, input logic en);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    therm_in = t;
    dwa_en   = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 18'h0, 1'b1);
    step(1'b1, 1'b1, 18'h3ffff, 1'b1);
    n_total++;
    if (elem_sel !== 18'h0) $display("FAIL reset_sel got %h want %h", elem_sel, 18'h0);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_ov got %b want 0", out_valid);
    else n_pass++;
    n_total++;
    if (ptr !== 5'd0) $display("FAIL reset_ptr got %0d want 0", ptr);
    else n_pass++;
    n_total++;
    if (therm_err !== 1'b0) $display("FAIL reset_err got %b want 0", therm_err);
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [17:0] tin [3];
    logic [17:0] esel[3];
    logic [4:0]  eptr[3];
    tin[0] = 18'b000000000000011111; esel[0] = 18'b000000000000011111; eptr[0] = 5'd5;
    tin[1] = 18'b000000000000011111; esel[1] = 18'b000000001111100000; eptr[1] = 5'd10;
    tin[2] = 18'b000000001111111111; esel[2] = 18'b111111110000000011; eptr[2] = 5'd2;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, tin[i], 1'b1);
      n_total++;
      if (elem_sel !== esel[i]) $display("FAIL seq_sel[%0d] got %b want %b", i, elem_sel, esel[i]);
      else n_pass++;
      n_total++;
      if (ptr !== eptr[i]) $display("FAIL seq_ptr[%0d] got %0d want %0d", i, ptr, eptr[i]);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL seq_ov[%0d] got %b want 1", i, out_valid);
      else n_pass++;
      n_total++;
      if (therm_err !== 1'b0) $display("FAIL seq_err[%0d] got %b want 0", i, therm_err);
      else n_pass++;
    end
    step(1'b0, 1'b0, 18'h3ffff, 1'b1);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL idle_ov got %b want 0", out_valid);
    else n_pass++;
    n_total++;
    if (elem_sel !== 18'b111111110000000011)
      $display("FAIL idle_sel got %b want %b", elem_sel, 18'b111111110000000011);
    else n_pass++;
    n_total++;
    if (ptr !== 5'd2) $display("FAIL idle_ptr got %0d want 2", ptr);
    else n_pass++;
  endtask

  task automatic test_full_zero();
    step(1'b0, 1'b1, 18'h3ffff, 1'b1);
    n_total++;
    if (elem_sel !== 18'h3ffff) $display("FAIL full_sel got %h want 3ffff", elem_sel);
    else n_pass++;
    n_total++;
    if (ptr !== 5'd2) $display("FAIL full_ptr got %0d want 2", ptr);
    else n_pass++;
    step(1'b0, 1'b1, 18'h0, 1'b1);
    n_total++;
    if (elem_sel !== 18'h0) $display("FAIL zero_sel got %h want 0", elem_sel);
    else n_pass++;
    n_total++;
    if (ptr !== 5'd2) $display("FAIL zero_ptr got %0d want 2", ptr);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL zero_ov got %b want 1", out_valid);
    else n_pass++;
  endtask

  task automatic test_bypass();
    // Advance 2 -> 7 with five elements at bits 2..6.
    step(1'b0, 1'b1, 18'h0001f, 1'b1);
    n_total++;
    if (elem_sel !== 18'h0007c || ptr !== 5'd7)
      $display("FAIL to7 got sel %h ptr %0d want 0007c/7", elem_sel, ptr);
    else n_pass++;
    step(1'b0, 1'b1, 18'b000000000000000111, 1'b0);
    n_total++;
    if (elem_sel !== 18'b000000000000000111)
      $display("FAIL byp_sel got %b want %b", elem_sel, 18'b000000000000000111);
    else n_pass++;
    n_total++;
    if (ptr !== 5'd7) $display("FAIL byp_ptr got %0d want 7", ptr);
    else n_pass++;
    step(1'b0, 1'b1, 18'b000000000000000111, 1'b1);
    n_total++;
    if (elem_sel !== 18'b000000001110000000)
      $display("FAIL reen_sel got %b want %b", elem_sel, 18'b000000001110000000);
    else n_pass++;
    n_total++;
    if (ptr !== 5'd10) $display("FAIL reen_ptr got %0d want 10", ptr);
    else n_pass++;
  endtask

  task automatic test_bubble();
    step(1'b0, 1'b1, 18'b000000000000000101, 1'b1);
    n_total++;
    if (therm_err !== 1'b1) $display("FAIL bub_err got %b want 1", therm_err);
    else n_pass++;
    n_total++;
    if (elem_sel !== 18'h00c00) $display("FAIL bub_sel got %h want 00c00", elem_sel);
    else n_pass++;
    n_total++;
    if (ptr !== 5'd12) $display("FAIL bub_ptr got %0d want 12", ptr);
    else n_pass++;
    step(1'b0, 1'b0, 18'h0, 1'b1);
    n_total++;
    if (therm_err !== 1'b0) $display("FAIL bub_pulse got %b want 0", therm_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 18'h00001, 1'b1);
    n_total++;
    if (ptr !== 5'd13 || elem_sel !== 18'h01000)
      $display("FAIL to13 got sel %h ptr %0d want 01000/13", elem_sel, ptr);
    else n_pass++;
    step(1'b1, 1'b1, 18'h0003f, 1'b1);
    n_total++;
    if (elem_sel !== 18'h0 || ptr !== 5'd0 || out_valid !== 1'b0)
      $display("FAIL rmid got sel %h ptr %0d ov %b want 0/0/0", elem_sel, ptr, out_valid);
    else n_pass++;
    step(1'b0, 1'b1, 18'h00007, 1'b1);
    n_total++;
    if (elem_sel !== 18'h00007 || ptr !== 5'd3)
      $display("FAIL post_rst got sel %h ptr %0d want 00007/3", elem_sel, ptr);
    else n_pass++;
  endtask

  task automatic test_soak();
    int          mptr;
    int          use_cnt[18];
    int          cnt;
    int          mx;
    int          mn;
    logic        v;
    logic [18:0] code;
    logic [17:0] esel;
    step(1'b1, 1'b0, 18'h0, 1'b1);
    mptr = 0;
    esel = '0;
    for (int j = 0; j < 18; j++) use_cnt[j] = 0;
    for (int k = 0; k < 10000; k++) begin
      v    = ($urandom_range(0, 3) != 0);
      cnt  = $urandom_range(0, 18);
      code = (19'd1 << cnt) - 19'd1;
      step(1'b0, v, code[17:0], 1'b1);
      if (v) begin
        esel = '0;
        for (int i = 0; i < cnt; i++) esel[(mptr + i) % 18] = 1'b1;
        mptr = (mptr + cnt) % 18;
        for (int j = 0; j < 18; j++) use_cnt[j] += int'(elem_sel[j]);
      end
      n_total++;
      if (elem_sel !== esel || ptr !== 5'(mptr) || out_valid !== v || therm_err !== 1'b0)
        $display("FAIL soak[%0d] got sel %h ptr %0d ov %b err %b want %h/%0d/%b/0",
                 k, elem_sel, ptr, out_valid, therm_err, esel, mptr, v);
      else n_pass++;
      mx = use_cnt[0];
      mn = use_cnt[0];
      for (int j = 1; j < 18; j++) begin
        if (use_cnt[j] > mx) mx = use_cnt[j];
        if (use_cnt[j] < mn) mn = use_cnt[j];
      end
      n_total++;
      if (mx - mn > 1) $display("FAIL soak_bal[%0d] got spread %0d want <=1", k, mx - mn);
      else n_pass++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    therm_in = '0;
    dwa_en   = 1'b1;
    test_reset();
    test_sequence();
    test_full_zero();
    test_bypass();
    test_bubble();
    test_reset_mid();
    test_soak();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
